mul_seq_arbiter: RTL and testbench

MUL_SEQ_ARBITER -- requirements
Module: mul_seq_arbiter

---
 rtl/mul_seq_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mul_seq_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_arbiter.sv
// -----------------------------------------------------------------------------
// mul_seq_arbiter
//
// Round-robin arbiter in front of a sequential constant multiplier. When idle,
// it grants one requester, captures its operand, and then streams four result
// beats for that operand: x1, x3, x7 and x8. One beat is produced per advancing
// clock edge. A beat is held while it is valid and not yet accepted downstream.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   [NREQ]      per-requester request (held until granted)
//   data       in   [NREQ*DW]   packed operands, requester i at [i*DW +: DW]
//   gnt        out  [NREQ]      one-hot, one-cycle grant pulse
//   out        out  [DW+3]      current result beat
//   out_valid  out              out carries a beat this cycle
//   out_id     out  [clog2]     requester that owns out
//   out_step   out  [2]         0=x1, 1=x3, 2=x7, 3=x8
//   out_ready  in               downstream accepts out when valid && ready
//   busy       out              high while a job is in RUN
// -----------------------------------------------------------------------------
module mul_seq_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   localparam int IDW = $clog2(NREQ),
   localparam int RW  = DW + 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   data,
   output logic [NREQ-1:0]      gnt,
   output logic [RW-1:0]        out,
   output logic                 out_valid,
   output logic [IDW-1:0]       out_id,
   output logic [1:0]           out_step,
   input  logic                 out_ready,
   output logic                 busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [1:0]        cnt_q;
   logic [DW-1:0]     op_q;
   logic [NREQ-1:0]   gnt_q;
   logic [RW-1:0]     out_q;
   logic              out_valid_q;
   logic [IDW-1:0]    out_id_q;
   logic [1:0]        out_step_q;
   logic              busy_q;
   logic [IDW-1:0]    last_grant_q;

   logic              advance_d;
   logic              arb_found_d;
   logic [IDW-1:0]    arb_winner_d;
   logic [DW-1:0]     arb_operand_d;

   // Result for a given step, widened first so that 8*op never truncates.
   // x3 and x7 use shift-and-subtract so no multiplier is needed.
   function automatic logic [RW-1:0] step_result(input logic [DW-1:0] op,
                                                 input logic [1:0]    step);
      logic [RW-1:0] ext;
      logic [RW-1:0] res;
      ext = {3'b000, op};
      case (step)
         2'd0:    res = ext;
         2'd1:    res = (ext << 2) - ext;
         2'd2:    res = (ext << 3) - ext;
         2'd3:    res = ext << 3;
         default: res = ext;
      endcase
      return res;
   endfunction

   // One-hot vector with a single bit set at position idx.
   function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
      logic [NREQ-1:0] v;
      v = {{(NREQ-1){1'b0}}, 1'b1} << idx;
      return v;
   endfunction

   // The pipeline moves only when the current beat is empty or being taken.
   assign advance_d = ~out_valid_q | out_ready;

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      logic [IDW-1:0] cand_v;
      arb_found_d  = 1'b0;
      arb_winner_d = '0;
      cand_v       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_v = IDW'((int'(last_grant_q) + k) % NREQ);
         if (!arb_found_d && req[cand_v]) begin
            arb_found_d  = 1'b1;
            arb_winner_d = cand_v;
         end else begin
            arb_found_d  = arb_found_d;
         end
      end
   end

   // Operand of the arbitration winner.
   assign arb_operand_d = data[arb_winner_d*DW +: DW];

   // Control FSM, step counter and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 2'd0;
         op_q         <= '0;
         gnt_q        <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         out_id_q     <= '0;
         out_step_q   <= 2'd0;
         busy_q       <= 1'b0;
         last_grant_q <= IDW'(NREQ - 1);
      end else if (advance_d) begin
         // Grant is a pulse: cleared on every edge that does not grant.
         gnt_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (arb_found_d) begin
                  op_q         <= arb_operand_d;
                  gnt_q        <= onehot(arb_winner_d);
                  last_grant_q <= arb_winner_d;
                  out_q        <= step_result(arb_operand_d, 2'd0);
                  out_id_q     <= arb_winner_d;
                  out_step_q   <= 2'd0;
                  out_valid_q  <= 1'b1;
                  cnt_q        <= 2'd1;
                  state_q      <= ST_RUN;
                  busy_q       <= 1'b1;
               end else begin
                  // Nothing to do: drop valid, keep the last beat visible.
                  out_valid_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               out_q       <= step_result(op_q, cnt_q);
               out_step_q  <= cnt_q;
               out_valid_q <= 1'b1;
               if (cnt_q == 2'd3) begin
                  // Last beat issued; next advancing edge may arbitrate again.
                  cnt_q   <= 2'd0;
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q + 2'd1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cnt_q       <= 2'd0;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end else begin
         // Stalled: everything holds except the grant pulse, which must end.
         gnt_q <= '0;
      end
   end

   assign gnt       = gnt_q;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign out_step  = out_step_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mul_seq_arbiter.sv
module tb_mul_seq_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int IDW  = 2;
   localparam int RW   = DW + 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ*DW-1:0]  data;
   logic [NREQ-1:0]     gnt;
   logic [RW-1:0]       out;
   logic                out_valid;
   logic [IDW-1:0]      out_id;
   logic [1:0]          out_step;
   logic                out_ready;
   logic                busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of pending beats for the job in flight
   int m_valid, m_out, m_id, m_step, m_gnt, m_last;
   int q_out[$];
   int q_step[$];
   int mult[4] = '{1, 3, 7, 8};

   mul_seq_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
      .out(out), .out_valid(out_valid), .out_id(out_id), .out_step(out_step),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_out = 0; m_id = 0; m_step = 0; m_gnt = 0;
      m_last = NREQ - 1;
      q_out.delete();
      q_step.delete();
   endtask

   // One clock edge of the model, using the inputs present before the edge
   task automatic model_edge();
      int w, op;
      m_gnt = 0;
      if (m_valid == 0 || out_ready) begin
         if (q_out.size() > 0) begin
            m_out  = q_out.pop_front();
            m_step = q_step.pop_front();
            m_valid = 1;
         end else if (req != '0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
               if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            end
            m_last = w;
            m_gnt  = 1 << w;
            op     = int'(data[w*DW +: DW]);
            for (int s = 1; s < 4; s++) begin
               q_out.push_back(op * mult[s]);
               q_step.push_back(s);
            end
            m_out = op; m_step = 0; m_id = w; m_valid = 1;
         end else begin
            m_valid = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".gnt"},       32'(gnt),       32'(m_gnt));
      chk({tag, ".out"},       32'(out),       32'(m_out));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ".out_id"},    32'(out_id),    32'(m_id));
      chk({tag, ".out_step"},  32'(out_step),  32'(m_step));
      chk({tag, ".busy"},      32'(busy),      32'(q_out.size() > 0));
   endtask

   // Advance one clock, check against model, and let granted requesters drop req
   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
      for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) req[i] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = '0;
      data = '0;
      out_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; req = '0; data = '0; out_ready = 1'b1;

      // Single job, operand 5
      do_reset();
      data[7:0] = 8'd5; req = 4'b0001;
      cycle("j5_0"); chk("j5_gnt", 32'(gnt), 32'd1); chk("j5_b0", 32'(out), 32'd5);
      chk("j5_id", 32'(out_id), 32'd0);
      cycle("j5_1"); chk("j5_b1", 32'(out), 32'd15); chk("j5_gnt_off", 32'(gnt), 32'd0);
      cycle("j5_2"); chk("j5_b2", 32'(out), 32'd35);
      cycle("j5_3"); chk("j5_b3", 32'(out), 32'd40); chk("j5_s3", 32'(out_step), 32'd3);
      cycle("j5_4"); chk("j5_idle", 32'(out_valid), 32'd0);

      // All four requesting: back-to-back jobs in order 0..3
      do_reset();
      data = {8'd4, 8'd3, 8'd2, 8'd1}; req = 4'b1111;
      for (int c = 0; c < 16; c++) begin
         cycle("rr");
         chk("rr_valid", 32'(out_valid), 32'd1);
         chk("rr_out", 32'(out), 32'((c / 4 + 1) * mult[c % 4]));
         if (c % 4 == 0) chk("rr_gnt", 32'(gnt), 32'(1 << (c / 4)));
      end
      cycle("rr_end"); chk("rr_idle", 32'(out_valid), 32'd0);

      // Maximum operand: no truncation
      do_reset();
      data[7:0] = 8'd255; req = 4'b0001;
      cycle("max0"); chk("max_b0", 32'(out), 32'd255);
      cycle("max1"); chk("max_b1", 32'(out), 32'd765);
      cycle("max2"); chk("max_b2", 32'(out), 32'd1785);
      cycle("max3"); chk("max_b3", 32'(out), 32'd2040);

      // Backpressure during step 1, with a competing request raised mid-stall
      do_reset();
      data[7:0] = 8'd10; req = 4'b0001;
      cycle("st0");
      cycle("st1"); chk("st_b1", 32'(out), 32'd30);
      out_ready = 1'b0; data[23:16] = 8'd6; req[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cycle("stall");
         chk("stall_out", 32'(out), 32'd30);
         chk("stall_step", 32'(out_step), 32'd1);
         chk("stall_gnt", 32'(gnt), 32'd0);
      end
      out_ready = 1'b1;
      cycle("st2"); chk("st_b2", 32'(out), 32'd70);
      cycle("st3"); chk("st_b3", 32'(out), 32'd80);
      cycle("st4"); chk("st_next_gnt", 32'(gnt), 32'b0100);
      repeat (4) cycle("st_drain");

      // Reset during step 2, then arbitration restarts from requester 0
      do_reset();
      data[7:0] = 8'd9; req = 4'b0001;
      cycle("rs0"); cycle("rs1"); cycle("rs2");
      chk("rs_b2", 32'(out), 32'd63);
      rst = 1'b1;
      #1;
      chk("rs_out", 32'(out), 32'd0);
      chk("rs_valid", 32'(out_valid), 32'd0);
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_step", 32'(out_step), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      data[15:8] = 8'd7; data[23:16] = 8'd11; req = 4'b0110;
      cycle("rs_after"); chk("rs_gnt", 32'(gnt), 32'b0010);
      repeat (8) cycle("rs_drain");

      // Wrap-around priority: 0 first after reset, then 3
      do_reset();
      data[7:0] = 8'd2; data[31:24] = 8'd5; req = 4'b1001;
      cycle("wr0"); chk("wr_gnt0", 32'(gnt), 32'b0001);
      req[0] = 1'b1;
      repeat (3) cycle("wr_run");
      cycle("wr4"); chk("wr_gnt3", 32'(gnt), 32'b1000);
      chk("wr_out", 32'(out), 32'd5);
      repeat (8) cycle("wr_drain");

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         out_ready = ($urandom_range(3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(3) == 0) begin
               data[i*DW +: DW] = DW'($urandom);
               req[i] = 1'b1;
            end
         end
         cycle("rnd");
      end
      req = '0; out_ready = 1'b1;
      repeat (8) cycle("rnd_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
